// File: rtl/sayuru_mem_responder.sv
// sayuru_mem_responder: single-outstanding main-memory model speaking req/gnt/rvalid
// with programmable grant and response latency and per-type transaction counters.
module sayuru_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int GNT_LATENCY    = 1,
    parameter int RVALID_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic [31:0]             read_count_o,
    output logic [31:0]             write_count_o,
    output logic                    protocol_err_o
);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT_GNT, GRANT, WAIT_RESP, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] resp_data, rdata_q;
    logic                  resp_we;
    logic                  granted;
    logic [IW-1:0]         idx;
    logic                  unused_addr;

    assign idx         = data_addr_i[IW+1:2];
    assign unused_addr = ^data_addr_i;
    assign granted     = (state == GRANT) && data_req_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            rdata_q        <= '0;
            resp_we        <= 1'b0;
            read_count_o   <= '0;
            write_count_o  <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= data_rdata_o;
            if (granted) begin
                resp_we <= data_we_i;
                if (data_we_i) write_count_o <= write_count_o + 32'd1;
                else           read_count_o  <= read_count_o + 32'd1;
            end
            if ((state == WAIT_GNT || state == GRANT) && !data_req_i)
                protocol_err_o <= 1'b1;
        end
    end

    // Storage is never reset; writes and read capture both commit at the grant edge.
    always_ff @(posedge clk) begin
        if (granted) begin
            if (data_we_i) begin
                for (int i = 0; i < DATA_WIDTH/8; i++)
                    if (data_be_i[i]) mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
            end else begin
                resp_data <= mem[idx];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (data_req_i) begin
                cnt_nxt   = 4'(GNT_LATENCY - 1);
                state_nxt = (GNT_LATENCY == 1) ? GRANT : WAIT_GNT;
            end
            WAIT_GNT: begin
                cnt_nxt   = cnt - 4'd1;
                state_nxt = !data_req_i ? IDLE : (cnt == 4'd1) ? GRANT : WAIT_GNT;
            end
            GRANT: begin
                cnt_nxt   = 4'(RVALID_LATENCY - 1);
                state_nxt = !data_req_i ? IDLE : (RVALID_LATENCY == 1) ? RESP : WAIT_RESP;
            end
            WAIT_RESP: begin
                cnt_nxt   = cnt - 4'd1;
                state_nxt = (cnt == 4'd1) ? RESP : WAIT_RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_gnt_o    = granted;
        data_rvalid_o = (state == RESP);
        data_rdata_o  = (state == RESP && !resp_we) ? resp_data : rdata_q;
    end
endmodule

// File: tb/tb_sayuru_mem_responder.sv
// tb_sayuru_mem_responder: directed scoreboard bench over a default-latency instance
// and a GNT_LATENCY=3 / RVALID_LATENCY=4 instance sharing clock, reset and request fields.
module tb_sayuru_mem_responder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, we = 1'b0;
    logic [15:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt_a, rv_a, err_a, gnt_b, rv_b, err_b;
    logic [31:0] rdata_a, rc_a, wc_a, rdata_b, rc_b, wc_b;

    int          n_chk = 0, n_err = 0;
    logic [31:0] model[int];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd[2], rc_exp[2], wc_exp[2];

    always #5 clk = ~clk;

    sayuru_mem_responder dut_a (
        .clk(clk), .rst_n(rst_n), .data_req_i(req_a), .data_gnt_o(gnt_a), .data_rvalid_o(rv_a),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rdata_o(rdata_a), .read_count_o(rc_a), .write_count_o(wc_a), .protocol_err_o(err_a)
    );

    sayuru_mem_responder #(.GNT_LATENCY(3), .RVALID_LATENCY(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_req_i(req_b), .data_gnt_o(gnt_b), .data_rvalid_o(rv_b),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rdata_o(rdata_b), .read_count_o(rc_b), .write_count_o(wc_b), .protocol_err_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int s);
        return s != 0 ? gnt_b : gnt_a;
    endfunction
    function automatic logic rv_of(input int s);
        return s != 0 ? rv_b : rv_a;
    endfunction
    function automatic logic [31:0] rdata_of(input int s);
        return s != 0 ? rdata_b : rdata_a;
    endfunction

    task automatic set_req(input int s, input logic v);
        if (s != 0) req_b = v; else req_a = v;
    endtask

    task automatic check_counts(input int s);
        chk("read_count", s != 0 ? rc_b : rc_a, rc_exp[s]);
        chk("write_count", s != 0 ? wc_b : wc_a, wc_exp[s]);
    endtask

    task automatic txn(input int s, input logic w, input logic [15:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        int          gl, rl, k, j, key;
        logic [31:0] e, old;
        gl  = s != 0 ? 3 : 1;
        rl  = s != 0 ? 4 : 2;
        key = s * 4096 + int'(a[11:2]);
        if (w) begin
            old = model.exists(key) ? model[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (b[i]) old[8*i +: 8] = d[8*i +: 8];
            model[key] = old;
            exp_q.push_back(last_rd[s]);
            wc_exp[s]++;
        end else begin
            exp_q.push_back(model[key]);
            rc_exp[s]++;
        end
        @(negedge clk);
        we = w; addr = a; be = b; wdata = d;
        set_req(s, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!gnt_of(s) && k < 40);
        chk("gnt_latency", k, gl);
        @(posedge clk); #1;
        set_req(s, 1'b0);
        addr = 16'($urandom); we = 1'($urandom); be = 4'($urandom); wdata = $urandom;
        j = k;
        do begin @(negedge clk); j++; end while (!rv_of(s) && j < k + 40);
        chk("rvalid_latency", j, gl + rl);
        e = exp_q.pop_front();
        chk("rdata", rdata_of(s), e);
        if (!w) last_rd[s] = e;
        @(negedge clk);
        chk("rvalid_one_cycle", rv_of(s), 0);
        chk("rdata_hold", rdata_of(s), last_rd[s]);
        check_counts(s);
    endtask

    initial begin
        int          gq[$], rq[$];
        logic [31:0] e;
        logic        saw;
        for (int s = 0; s < 2; s++) begin last_rd[s] = 0; rc_exp[s] = 0; wc_exp[s] = 0; end

        // Reset state
        #1;
        chk("rst_gnt", {gnt_a, gnt_b}, 0);
        chk("rst_rvalid", {rv_a, rv_b}, 0);
        chk("rst_rdata", rdata_a | rdata_b, 0);
        chk("rst_err", {err_a, err_b}, 0);
        check_counts(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full write then read at default latency
        txn(0, 1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF);
        txn(0, 1'b0, 16'h0010, 4'hF, 32'h0);
        chk("raw_value", last_rd[0], 32'hDEAD_BEEF);

        // Reset while the response is pending
        @(negedge clk);
        we = 1'b0; addr = 16'h0010; req_a = 1'b1;
        @(negedge clk);
        chk("abort_gnt", gnt_a, 1);
        @(posedge clk); #1;
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rdata", rdata_a, 0);
        chk("abort_outs", {gnt_a, rv_a, err_a}, 0);
        chk("abort_counts", rc_a | wc_a, 0);
        saw = 1'b0;
        repeat (4) begin @(negedge clk); saw = saw | rv_a; end
        chk("abort_no_rvalid", saw, 0);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin last_rd[s] = 0; rc_exp[s] = 0; wc_exp[s] = 0; end

        // Byte enables, including the empty write
        txn(0, 1'b1, 16'h0020, 4'hF, 32'h1122_3344);
        txn(0, 1'b1, 16'h0020, 4'b0101, 32'hAABB_CCDD);
        txn(0, 1'b0, 16'h0020, 4'hF, 32'h0);
        chk("be_merge", last_rd[0], 32'h11BB_33DD);
        txn(0, 1'b1, 16'h0022, 4'h0, 32'hFFFF_FFFF);
        txn(0, 1'b0, 16'h0023, 4'hF, 32'h0);
        chk("be_zero", last_rd[0], 32'h11BB_33DD);

        // Address aliasing modulo 4 KiB
        txn(0, 1'b1, 16'h1004, 4'hF, 32'h5A5A_5A5A);
        txn(0, 1'b0, 16'h0004, 4'hF, 32'h0);
        chk("alias", last_rd[0], 32'h5A5A_5A5A);

        // Read counter wrap
        @(negedge clk);
        force dut_a.read_count_o = 32'hFFFF_FFFF;
        #1 release dut_a.read_count_o;
        chk("wrap_preset", rc_a, 32'hFFFF_FFFF);
        rc_exp[0] = 32'hFFFF_FFFF;
        txn(0, 1'b0, 16'h0004, 4'hF, 32'h0);
        chk("wrap_zero", rc_a, 0);

        // Long-latency instance and back-to-back period
        txn(1, 1'b1, 16'h0040, 4'hF, 32'hCAFE_F00D);
        exp_q.push_back(32'hCAFE_F00D);
        exp_q.push_back(32'hCAFE_F00D);
        rc_exp[1] += 2;
        @(negedge clk);
        we = 1'b0; addr = 16'h0040; req_b = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (gnt_b) gq.push_back(c);
            if (rv_b) begin
                rq.push_back(c);
                e = exp_q.pop_front();
                chk("b2b_rdata", rdata_b, e);
            end
            if (c == 11) begin @(posedge clk); #1 req_b = 1'b0; end
        end
        chk("b2b_gnt_count", gq.size(), 2);
        chk("b2b_gnt0", gq[0], 3);
        chk("b2b_gnt1", gq[1], 11);
        chk("b2b_rv0", rq[0], 7);
        chk("b2b_rv1", rq[1], 15);
        last_rd[1] = 32'hCAFE_F00D;
        check_counts(1);

        // Request withdrawn before grant
        @(negedge clk);
        we = 1'b0; addr = 16'h0040; req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        saw = 1'b0;
        repeat (8) begin @(negedge clk); saw = saw | gnt_b | rv_b; end
        chk("perr_no_gnt", saw, 0);
        chk("perr_set", err_b, 1);
        check_counts(1);
        txn(1, 1'b0, 16'h0040, 4'hF, 32'h0);
        chk("perr_sticky", err_b, 1);
        chk("perr_other_clear", err_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sayuru_mem_responder.md
Name: sayuru_mem_responder

Overview:
- Main-memory model on the downstream side of the Sayuru n-way cache's memory port.
- Consumes the cache's miss-fill and writeback traffic: read requests and word/byte write requests.
- Speaks the core memory protocol (req/gnt/rvalid) with programmable grant and response latency, so cache miss penalties can be swept in simulation and on FPGA.
- Holds one outstanding transaction at a time and keeps per-type transaction counters.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, data word width; must be 32.
- MEM_DEPTH, 1024, storage depth in words; power of 2.
- GNT_LATENCY, 1, cycles from first sampled req to gnt; range 1..15.
- RVALID_LATENCY, 2, cycles from the gnt cycle to the rvalid cycle; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  request, held by the master until granted.
- data_gnt_o  out  1  grant, one-cycle pulse.
- data_rvalid_o  out  1  response valid, one-cycle pulse; issued for reads and writes.
- data_addr_i  in  ADDR_WIDTH  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_rdata_o  out  DATA_WIDTH  read data, valid when rvalid is high.
- read_count_o  out  32  granted reads.
- write_count_o  out  32  granted writes.
- protocol_err_o  out  1  sticky flag: req was withdrawn before gnt.

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs return to 0 and the FSM returns to IDLE.
  - Latency counters clear.
  - Memory contents are not cleared.
- Reset mid-transaction aborts the transaction. No gnt or rvalid is issued for it, and any write not yet granted never occurs.
- Word index = data_addr_i[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo MEM_DEPTH*4 bytes. Address bits [1:0] are ignored.
- FSM states:
  - IDLE:
    - req=1 at cycle t: load the counter with GNT_LATENCY-1.
    - If GNT_LATENCY=1, go to GRANT; otherwise go to WAIT_GNT.
  - WAIT_GNT:
    - Decrement the counter each cycle. Go to GRANT when it reaches 0.
    - If req=0 in any WAIT_GNT cycle: set protocol_err_o, go to IDLE, issue no gnt.
  - GRANT:
    - gnt_o=1 for exactly this cycle, i.e. cycle t+GNT_LATENCY.
    - At the clock edge ending this cycle, capture addr, we, be and wdata.
    - Write: update only the bytes with be[i]=1. be=0000 is a legal no-op write.
    - Read: latch mem[index] into an internal response register.
    - Increment read_count_o or write_count_o. Counters wrap 0xFFFFFFFF -> 0.
    - If req=0 in this cycle: set protocol_err_o, issue no gnt, go to IDLE.
    - Otherwise load the counter with RVALID_LATENCY-1 and go to RESP if RVALID_LATENCY=1, else WAIT_RESP.
  - WAIT_RESP: decrement the counter; go to RESP at 0.
  - RESP:
    - rvalid_o=1 for one cycle, at grant cycle + RVALID_LATENCY.
    - Read: rdata_o = latched word. Write: rdata_o holds its previous value.
    - Next state is IDLE.
- req is sampled only in IDLE. A req still high during the RESP cycle counts as a new request from the following IDLE cycle.
  - Back-to-back period = GNT_LATENCY + RVALID_LATENCY + 1 cycles.
- Address, we, be and wdata may change freely after gnt without affecting the transaction in flight.
- rdata_o is stable between rvalid pulses.
- Read-after-write to the same word returns the written data, because the write commits at the grant edge.
- protocol_err_o is cleared only by reset.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT_RESP -> rvalid never pulses; all outputs 0; FSM in IDLE after release.
- Write then read, defaults: write 0x0000_0010 ← 0xDEADBEEF, be=1111; gnt at t+1, rvalid at t+3. Read of 0x10 -> rdata=0xDEADBEEF; write_count=1, read_count=1.
- Byte enables: preload word 0x20=0x11223344, write 0xAABBCCDD with be=0101 -> readback 0x11BB33DD. be=0000 write -> word unchanged, rvalid still issued.
- Latency sweep: GNT_LATENCY=3, RVALID_LATENCY=4, req held from cycle 10 -> gnt at 13, rvalid at 17; next request gnt at 21.
- Aliasing and counter wrap, MEM_DEPTH=1024:
  - Write 0x1004 ← 0x5A5A5A5A, read 0x0004 -> 0x5A5A5A5A.
  - Force read_count=0xFFFFFFFF, grant one read -> 0.
- Protocol error: GNT_LATENCY=3, req high 1 cycle then low -> no gnt, protocol_err_o=1, FSM in IDLE; a later legal read completes normally with the error still set.
